alu_result_encoder: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_enc_fifo.sv | 63 ++++++
 rtl/alu_result_encoder.sv | 108 ++++++++++
 tb/tb_alu_result_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: function-code constants and default datapath width.
// Used by both the function decoder and the result encoder.
package alu_pkg;

   localparam int unsigned ALU_OUT_WIDTH = 16;
   localparam int unsigned FUNC_W        = 2;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_ARITH = 2'b00,
      FUNC_LOGIC = 2'b01,
      FUNC_CMP   = 2'b10,
      FUNC_SHIFT = 2'b11
   } func_e;

endpackage

// File: rtl/alu_enc_fifo.sv
// Synchronous circular-buffer FIFO with occupancy level; empty head reads as zero.
module alu_enc_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/alu_result_encoder.sv
// ALU return path: encodes the single active unit flag into a function code and queues {code, result}.
// Optional saturating multi-flag error counter enabled by defining ALU_ENC_ERR_CNT_EN.
module alu_result_encoder
   import alu_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = ALU_OUT_WIDTH,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [OUT_WIDTH-1:0]       ENC_ARITH_OUT,
   input  logic [OUT_WIDTH-1:0]       ENC_LOGIC_OUT,
   input  logic [OUT_WIDTH-1:0]       ENC_CMP_OUT,
   input  logic [OUT_WIDTH-1:0]       ENC_SHIFT_OUT,
   input  logic                       ENC_ARITH_FLAG,
   input  logic                       ENC_LOGIC_FLAG,
   input  logic                       ENC_CMP_FLAG,
   input  logic                       ENC_SHIFT_FLAG,
   input  logic                       ENC_OUT_READY,
   output logic [OUT_WIDTH-1:0]       ENC_ALU_OUT,
   output logic [FUNC_W-1:0]          ENC_ALU_SRC,
   output logic                       ENC_OUT_VALID,
   output logic [$clog2(DEPTH):0]     ENC_LEVEL,
   output logic                       ENC_ERR,
   output logic                       ENC_OVF
`ifdef ALU_ENC_ERR_CNT_EN
   ,
   output logic [7:0]                 ENC_ERR_CNT
`endif
);

   localparam int unsigned DW = OUT_WIDTH + FUNC_W;

   logic [3:0]           flags;
   logic                 cand_valid;
   logic [FUNC_W-1:0]    cand_code;
   logic [OUT_WIDTH-1:0] cand_data;
   logic                 multi;
   logic                 pop, push, drop;
   logic                 fifo_full, fifo_empty;
   logic [DW-1:0]        head;
   logic                 err_q, ovf_q;

   assign flags = {ENC_SHIFT_FLAG, ENC_CMP_FLAG, ENC_LOGIC_FLAG, ENC_ARITH_FLAG};

   // Only a one-hot flag set yields a candidate; any multi-flag pattern is an error, never resolved.
   always_comb begin
      cand_valid = 1'b0;
      cand_code  = FUNC_ARITH;
      cand_data  = '0;
      multi      = 1'b0;
      case (flags)
         4'b0000: ;
         4'b0001: begin cand_valid = 1'b1; cand_code = FUNC_ARITH; cand_data = ENC_ARITH_OUT; end
         4'b0010: begin cand_valid = 1'b1; cand_code = FUNC_LOGIC; cand_data = ENC_LOGIC_OUT; end
         4'b0100: begin cand_valid = 1'b1; cand_code = FUNC_CMP;   cand_data = ENC_CMP_OUT;   end
         4'b1000: begin cand_valid = 1'b1; cand_code = FUNC_SHIFT; cand_data = ENC_SHIFT_OUT; end
         default: multi = 1'b1;
      endcase
   end

   assign pop  = ENC_OUT_VALID && ENC_OUT_READY;
   assign push = cand_valid && (!fifo_full || pop);
   assign drop = cand_valid && fifo_full && !pop;

   alu_enc_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({cand_code, cand_data}),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (ENC_LEVEL)
   );

   assign ENC_OUT_VALID = !fifo_empty;
   assign ENC_ALU_SRC   = head[DW-1 -: FUNC_W];
   assign ENC_ALU_OUT   = head[OUT_WIDTH-1:0];
   assign ENC_ERR       = err_q;
   assign ENC_OVF       = ovf_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         err_q <= multi;
         ovf_q <= drop;
      end
   end

`ifdef ALU_ENC_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST)                            err_cnt_q <= '0;
      else if (multi && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign ENC_ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_encoder.sv
// Self-checking bench for alu_result_encoder: reference model plus output scoreboard.
module tb_alu_result_encoder;
   import alu_pkg::*;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 4;
   localparam int unsigned LW = $clog2(D) + 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [W-1:0]  ENC_ARITH_OUT = '0, ENC_LOGIC_OUT = '0, ENC_CMP_OUT = '0, ENC_SHIFT_OUT = '0;
   logic          ENC_ARITH_FLAG = 1'b0, ENC_LOGIC_FLAG = 1'b0, ENC_CMP_FLAG = 1'b0, ENC_SHIFT_FLAG = 1'b0;
   logic          ENC_OUT_READY = 1'b0;
   logic [W-1:0]  ENC_ALU_OUT;
   logic [1:0]    ENC_ALU_SRC;
   logic          ENC_OUT_VALID;
   logic [LW-1:0] ENC_LEVEL;
   logic          ENC_ERR;
   logic          ENC_OVF;
`ifdef ALU_ENC_ERR_CNT_EN
   logic [7:0]    ENC_ERR_CNT;
`endif

   alu_result_encoder #(.OUT_WIDTH(W), .DEPTH(D)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ENC_ARITH_OUT  (ENC_ARITH_OUT),
      .ENC_LOGIC_OUT  (ENC_LOGIC_OUT),
      .ENC_CMP_OUT    (ENC_CMP_OUT),
      .ENC_SHIFT_OUT  (ENC_SHIFT_OUT),
      .ENC_ARITH_FLAG (ENC_ARITH_FLAG),
      .ENC_LOGIC_FLAG (ENC_LOGIC_FLAG),
      .ENC_CMP_FLAG   (ENC_CMP_FLAG),
      .ENC_SHIFT_FLAG (ENC_SHIFT_FLAG),
      .ENC_OUT_READY  (ENC_OUT_READY),
      .ENC_ALU_OUT    (ENC_ALU_OUT),
      .ENC_ALU_SRC    (ENC_ALU_SRC),
      .ENC_OUT_VALID  (ENC_OUT_VALID),
      .ENC_LEVEL      (ENC_LEVEL),
      .ENC_ERR        (ENC_ERR),
      .ENC_OVF        (ENC_OVF)
`ifdef ALU_ENC_ERR_CNT_EN
      ,
      .ENC_ERR_CNT    (ENC_ERR_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   logic [17:0] sb [$];
   int          tests = 0;
   int          fails = 0;
   int          mlevel = 0;
   int          mcnt = 0;
   logic        exp_err = 1'b0;
   logic        exp_ovf = 1'b0;

   // Drive one cycle at posedge+1, predict its effect, return #1 after the edge that consumes it.
   task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] l,
                        input logic [15:0] c, input logic [15:0] s, input logic rdy);
      int          n;
      logic        pop, push;
      logic [17:0] ent;
      RST = 1'b0;
      ENC_ARITH_FLAG = f[0]; ENC_LOGIC_FLAG = f[1]; ENC_CMP_FLAG = f[2]; ENC_SHIFT_FLAG = f[3];
      ENC_ARITH_OUT = a; ENC_LOGIC_OUT = l; ENC_CMP_OUT = c; ENC_SHIFT_OUT = s;
      ENC_OUT_READY = rdy;
      n = int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3]);
      case (f)
         4'b0001: ent = {2'b00, a};
         4'b0010: ent = {2'b01, l};
         4'b0100: ent = {2'b10, c};
         4'b1000: ent = {2'b11, s};
         default: ent = '0;
      endcase
      pop  = (mlevel > 0) && rdy;
      push = (n == 1) && ((mlevel < int'(D)) || pop);
      if (push) sb.push_back(ent);
      exp_ovf = (n == 1) && !push;
      exp_err = (n > 1);
      if (exp_err && mcnt < 255) mcnt++;
      mlevel = mlevel + (push ? 1 : 0) - (pop ? 1 : 0);
      @(posedge CLK); #1;
   endtask

   // Reset with garbage on every other input; all of it must be ignored.
   task automatic do_reset();
      RST = 1'b1;
      ENC_ARITH_FLAG = 1'b1; ENC_CMP_FLAG = 1'b1; ENC_OUT_READY = 1'b1;
      ENC_ARITH_OUT = 16'hDEAD;
      sb.delete();
      mlevel = 0; mcnt = 0; exp_err = 1'b0; exp_ovf = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      ENC_ARITH_FLAG = 1'b0; ENC_CMP_FLAG = 1'b0; ENC_OUT_READY = 1'b0;
   endtask

   // Scoreboard: every accepted head must match the oldest predicted entry.
   always @(negedge CLK) begin
      if (!RST && ENC_OUT_VALID && ENC_OUT_READY) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_pop: got %h/%h, required no output", ENC_ALU_SRC, ENC_ALU_OUT);
         end else begin
            logic [17:0] e;
            e = sb.pop_front();
            if ({ENC_ALU_SRC, ENC_ALU_OUT} !== e) begin
               fails++;
               $display("FAIL sb_pop: got %h/%h, required %h/%h", ENC_ALU_SRC, ENC_ALU_OUT, e[17:16], e[15:0]);
            end
         end
      end
   end

   task automatic test_reset();
      do_reset();
      tests++;
      if (ENC_OUT_VALID !== 1'b0 || ENC_LEVEL !== '0 || ENC_ERR !== 1'b0 || ENC_OVF !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: valid=%b level=%0d err=%b ovf=%b, required 0 0 0 0",
                  ENC_OUT_VALID, ENC_LEVEL, ENC_ERR, ENC_OVF);
      end
      tests++;
      if (ENC_ALU_OUT !== '0 || ENC_ALU_SRC !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h/%h, required 0/0000", ENC_ALU_SRC, ENC_ALU_OUT);
      end
`ifdef ALU_ENC_ERR_CNT_EN
      tests++;
      if (ENC_ERR_CNT !== 8'd0) begin
         fails++;
         $display("FAIL reset_cnt: got %0d, required 0", ENC_ERR_CNT);
      end
`endif
   endtask

   task automatic test_single_flags();
      logic [3:0]  fl [4];
      logic [15:0] dv [4];
      logic [1:0]  cd [4];
      fl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      dv = '{16'h0011, 16'h0022, 16'h0001, 16'h0100};
      cd = '{2'b00, 2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 4; i++) begin
         drive(fl[i], dv[i], dv[i], dv[i], dv[i], 1'b1);
         tests++;
         if (ENC_OUT_VALID !== 1'b1 || ENC_ALU_OUT !== dv[i] || ENC_ALU_SRC !== cd[i]) begin
            fails++;
            $display("FAIL single_%0d: valid=%b out=%h/%h, required 1 %h/%h",
                     i, ENC_OUT_VALID, ENC_ALU_SRC, ENC_ALU_OUT, cd[i], dv[i]);
         end
      end
      drive(4'b0000, '0, '0, '0, '0, 1'b1);
      tests++;
      if (ENC_LEVEL !== LW'(mlevel) || ENC_OUT_VALID !== 1'b0) begin
         fails++;
         $display("FAIL single_drain: level=%0d valid=%b, required %0d 0", ENC_LEVEL, ENC_OUT_VALID, mlevel);
      end
   endtask

   task automatic test_multi_flag();
      int lvl_before;
      drive(4'b0001, 16'h1234, '0, '0, '0, 1'b0);
      lvl_before = mlevel;
      drive(4'b0101, 16'hAAAA, '0, 16'h5555, '0, 1'b0);
      tests++;
      if (ENC_ERR !== 1'b1 || ENC_LEVEL !== LW'(lvl_before) || ENC_OVF !== 1'b0) begin
         fails++;
         $display("FAIL multi_err: err=%b level=%0d ovf=%b, required 1 %0d 0", ENC_ERR, ENC_LEVEL, ENC_OVF, lvl_before);
      end
`ifdef ALU_ENC_ERR_CNT_EN
      tests++;
      if (ENC_ERR_CNT !== 8'(mcnt)) begin
         fails++;
         $display("FAIL multi_cnt: got %0d, required %0d", ENC_ERR_CNT, mcnt);
      end
`endif
      drive(4'b0000, '0, '0, '0, '0, 1'b1);
      tests++;
      if (ENC_ERR !== 1'b0) begin
         fails++;
         $display("FAIL multi_pulse: err=%b, required 0", ENC_ERR);
      end
      drive(4'b0000, '0, '0, '0, '0, 1'b1);
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         drive(4'b1000, '0, '0, '0, 16'(i), 1'b0);
         tests++;
         if (ENC_LEVEL !== LW'(mlevel) || ENC_OVF !== exp_ovf || ENC_ALU_OUT !== 16'h0001 || ENC_ALU_SRC !== 2'b11) begin
            fails++;
            $display("FAIL ovf_push_%0d: level=%0d ovf=%b head=%h/%h, required %0d %b 3/0001",
                     i, ENC_LEVEL, ENC_OVF, ENC_ALU_SRC, ENC_ALU_OUT, mlevel, exp_ovf);
         end
      end
      for (int i = 0; i < 4; i++) drive(4'b0000, '0, '0, '0, '0, 1'b1);
      tests++;
      if (ENC_LEVEL !== '0 || ENC_OVF !== 1'b0) begin
         fails++;
         $display("FAIL ovf_drain: level=%0d ovf=%b, required 0 0", ENC_LEVEL, ENC_OVF);
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) drive(4'b0001, 16'h0100 + 16'(i), '0, '0, '0, 1'b0);
      drive(4'b0010, '0, 16'h0F0F, '0, '0, 1'b1);
      tests++;
      if (ENC_LEVEL !== LW'(4) || ENC_OVF !== 1'b0) begin
         fails++;
         $display("FAIL full_pushpop: level=%0d ovf=%b, required 4 0", ENC_LEVEL, ENC_OVF);
      end
      for (int i = 0; i < 4; i++) drive(4'b0000, '0, '0, '0, '0, 1'b1);
      tests++;
      if (ENC_LEVEL !== '0 || sb.size() != 0) begin
         fails++;
         $display("FAIL full_drain: level=%0d pending=%0d, required 0 0", ENC_LEVEL, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] f;
      for (int i = 0; i < 8; i++) begin
         f = 4'b0001 << $urandom_range(3, 0);
         drive(f, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
         tests++;
         if (ENC_LEVEL !== LW'(1) || ENC_OUT_VALID !== 1'b1) begin
            fails++;
            $display("FAIL b2b_%0d: level=%0d valid=%b, required 1 1", i, ENC_LEVEL, ENC_OUT_VALID);
         end
      end
      drive(4'b0000, '0, '0, '0, '0, 1'b1);
   endtask

   task automatic test_reset_midburst();
      for (int i = 0; i < 3; i++) drive(4'b0100, '0, '0, 16'hC000 + 16'(i), '0, 1'b0);
      drive(4'b0011, '0, '0, '0, '0, 1'b0);
      tests++;
      if (ENC_LEVEL !== LW'(3)) begin
         fails++;
         $display("FAIL midburst_fill: level=%0d, required 3", ENC_LEVEL);
      end
      do_reset();
      tests++;
      if (ENC_OUT_VALID !== 1'b0 || ENC_LEVEL !== '0 || ENC_ERR !== 1'b0) begin
         fails++;
         $display("FAIL midburst_reset: valid=%b level=%0d err=%b, required 0 0 0", ENC_OUT_VALID, ENC_LEVEL, ENC_ERR);
      end
`ifdef ALU_ENC_ERR_CNT_EN
      tests++;
      if (ENC_ERR_CNT !== 8'd0) begin
         fails++;
         $display("FAIL midburst_cnt: got %0d, required 0", ENC_ERR_CNT);
      end
`endif
   endtask

`ifdef ALU_ENC_ERR_CNT_EN
   task automatic test_err_saturation();
      for (int i = 0; i < 300; i++) drive(4'b1111, '0, '0, '0, '0, 1'b0);
      tests++;
      if (ENC_ERR_CNT !== 8'd255 || ENC_ERR !== 1'b1) begin
         fails++;
         $display("FAIL cnt_sat: cnt=%0d err=%b, required 255 1", ENC_ERR_CNT, ENC_ERR);
      end
      drive(4'b0000, '0, '0, '0, '0, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_flags();
      test_multi_flag();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_reset_midburst();
`ifdef ALU_ENC_ERR_CNT_EN
      test_err_saturation();
`endif
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_leftover: %0d entries never emerged, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
